// File: rtl/mem_arbiter_if.sv
// Requester, grant/response and RAM-side signals of the shared single-port RAM arbiter.
// slave = the arbiter itself; master = the core requesters plus the RAM instance around it.
interface mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [BE_W-1:0]   ram_be;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, ram_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           ram_en, ram_we, ram_addr, ram_wdata, ram_be
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, ram_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           ram_en, ram_we, ram_addr, ram_wdata, ram_be
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the single-port RAM: same-cycle grant, read data routed 1 cycle later.
// Backpressure: a requester holds req until gnt; data has priority, fetch forced after STARVE_MAX denials.
module mem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, RD_IF, RD_D} owner_t;

  owner_t            owner, owner_nxt;
  logic [CNT_W-1:0]  starve_cnt;
  logic              force_if;
  logic              if_gnt, d_gnt;
  logic              if_rvalid, d_rvalid;

  always_comb begin
    force_if = (starve_cnt >= CNT_W'(STARVE_MAX));
    d_gnt    = reset_n & bus.d_req & ~(bus.if_req & force_if);
    if_gnt   = reset_n & bus.if_req & ~d_gnt;
  end

  assign bus.if_gnt = if_gnt;
  assign bus.d_gnt  = d_gnt;

  // Winner's request goes to the RAM; byte enables only mean something on stores.
  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.ram_be    = '0;
    if (d_gnt) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = bus.d_we;
      bus.ram_addr  = bus.d_addr;
      bus.ram_wdata = bus.d_wdata;
      bus.ram_be    = bus.d_we ? bus.d_be : {BE_W{1'b0}};
    end else if (if_gnt) begin
      bus.ram_en    = 1'b1;
      bus.ram_addr  = bus.if_addr;
    end
  end

  always_comb begin
    owner_nxt = IDLE;
    if (if_gnt)
      owner_nxt = RD_IF;
    else if (d_gnt && !bus.d_we)
      owner_nxt = RD_D;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      owner <= IDLE;
    else
      owner <= owner_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || if_gnt || !bus.if_req)
      starve_cnt <= '0;
    else if (starve_cnt < CNT_W'(STARVE_MAX))
      starve_cnt <= starve_cnt + CNT_W'(1);
  end

  // Gating with reset_n drops a read that was in flight when reset arrived.
  assign if_rvalid     = reset_n && (owner == RD_IF);
  assign d_rvalid      = reset_n && (owner == RD_D);
  assign bus.if_rvalid = if_rvalid;
  assign bus.d_rvalid  = d_rvalid;
  assign bus.if_rdata  = if_rvalid ? bus.ram_rdata : '0;
  assign bus.d_rdata   = d_rvalid  ? bus.ram_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand sequences, then random traffic vs. a model.
module tb_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SM = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int passed = 0;
  int total  = 0;

  function automatic logic [31:0] init_word(input logic [11:0] a);
    if (a == 12'h010) return 32'hE2801001;
    return {4'hA, a, 4'h5, a};
  endfunction

  // RAM model: unwritten words read back as init_word(addr).
  logic [31:0] ram [0:4095];
  logic        written [0:4095];
  logic [31:0] ram_cur;
  always @(posedge clk) begin
    if (bus.ram_en) begin
      ram_cur = written[bus.ram_addr] ? ram[bus.ram_addr] : init_word(bus.ram_addr);
      if (bus.ram_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_be[b]) ram_cur[8*b +: 8] = bus.ram_wdata[8*b +: 8];
        ram[bus.ram_addr]     <= ram_cur;
        written[bus.ram_addr] <= 1'b1;
      end else begin
        bus.ram_rdata <= ram_cur;
      end
    end
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic rst, input logic ir, input logic [11:0] ia,
                       input logic dr, input logic dwe, input logic [11:0] da,
                       input logic [31:0] wd, input logic [3:0] be);
    reset_n     = rst;
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.d_req   = dr;
    bus.d_we    = dwe;
    bus.d_addr  = da;
    bus.d_wdata = wd;
    bus.d_be    = be;
  endtask

  typedef struct {
    logic        rst, ir, dr, dwe;
    logic [11:0] ia, da;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [5:0]  flags;   // {if_gnt, d_gnt, ram_en, ram_we, if_rvalid, d_rvalid}
    logic [31:0] ird, drd;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic ir, input logic [11:0] ia,
                              input logic dr, input logic dwe, input logic [11:0] da,
                              input logic [31:0] wd, input logic [3:0] be,
                              input logic [5:0] flags, input logic [31:0] ird,
                              input logic [31:0] drd);
    vec_t v;
    v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da;
    v.wd = wd; v.be = be; v.flags = flags; v.ird = ird; v.drd = drd;
    return v;
  endfunction

  function automatic logic [5:0] flags_now();
    return {bus.if_gnt, bus.d_gnt, bus.ram_en, bus.ram_we, bus.if_rvalid, bus.d_rvalid};
  endfunction

  vec_t vt [14];

  // Behavioural model state for the random phase
  logic [31:0] rmem [0:15];
  int          denied;
  int          last_rd;   // 0 none, 1 fetch, 2 data
  logic [31:0] last_dat;

  initial begin
    for (int a = 0; a < 4096; a++) written[a] = 1'b0;
  end

  initial begin
    // Reset with both requesting, then D,D,D,D,F starvation, store/load, single fetch.
    vt[0]  = mk(0, 1, 12'h010, 1, 0, 12'h200, 0, 0, 6'b000000, 0, 0);
    vt[1]  = mk(0, 1, 12'h010, 1, 0, 12'h200, 0, 0, 6'b000000, 0, 0);
    vt[2]  = mk(1, 1, 12'h010, 1, 0, 12'h200, 0, 0, 6'b011000, 0, 0);
    vt[3]  = mk(1, 1, 12'h010, 1, 0, 12'h200, 0, 0, 6'b011001, 0, init_word(12'h200));
    vt[4]  = mk(1, 1, 12'h010, 1, 0, 12'h200, 0, 0, 6'b011001, 0, init_word(12'h200));
    vt[5]  = mk(1, 1, 12'h010, 1, 0, 12'h200, 0, 0, 6'b011001, 0, init_word(12'h200));
    vt[6]  = mk(1, 1, 12'h010, 1, 0, 12'h200, 0, 0, 6'b101001, 0, init_word(12'h200));
    vt[7]  = mk(1, 1, 12'h010, 1, 0, 12'h200, 0, 0, 6'b011010, 32'hE2801001, 0);
    vt[8]  = mk(1, 0, 12'h000, 0, 0, 12'h000, 0, 0, 6'b000001, 0, init_word(12'h200));
    vt[9]  = mk(1, 0, 12'h000, 1, 1, 12'h100, 32'hDEADBEEF, 4'hF, 6'b011100, 0, 0);
    vt[10] = mk(1, 0, 12'h000, 1, 0, 12'h100, 0, 0, 6'b011000, 0, 0);
    vt[11] = mk(1, 0, 12'h000, 0, 0, 12'h000, 0, 0, 6'b000001, 0, 32'hDEADBEEF);
    vt[12] = mk(1, 1, 12'h010, 0, 0, 12'h000, 0, 0, 6'b101000, 0, 0);
    vt[13] = mk(1, 0, 12'h000, 0, 0, 12'h000, 0, 0, 6'b000010, 32'hE2801001, 0);

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].rst, vt[i].ir, vt[i].ia, vt[i].dr, vt[i].dwe, vt[i].da, vt[i].wd, vt[i].be);
      @(negedge clk);
      chk($sformatf("vec%0d flags", i), {90'd0, flags_now()}, {90'd0, vt[i].flags});
      chk($sformatf("vec%0d rdata", i), {32'd0, bus.if_rdata, bus.d_rdata},
          {32'd0, vt[i].ird, vt[i].drd});
      @(posedge clk); #1;
    end

    // Load granted, reset falls next cycle: the load must never report rvalid.
    drive(1, 0, 0, 1, 0, 12'h005, 0, 0);
    @(negedge clk);
    chk("midrst grant", {94'd0, bus.d_gnt, bus.ram_en}, {94'd0, 2'b11});
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("midrst d_rvalid", {63'd0, bus.d_rvalid, bus.d_rdata}, 96'd0);
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("postrst idle", {94'd0, bus.if_rvalid, bus.d_rvalid}, 96'd0);
    @(posedge clk); #1;

    // Alternating fetch 0x000 / load 0x004 every cycle, no bubbles.
    for (int k = 0; k <= 8; k++) begin
      logic [5:0]  ef;
      logic [31:0] eir, edr;
      if (k == 8) drive(1, 0, 0, 0, 0, 0, 0, 0);
      else if (k % 2 == 0) drive(1, 1, 12'h000, 0, 0, 0, 0, 0);
      else drive(1, 0, 0, 1, 0, 12'h004, 0, 0);
      ef  = {(k < 8) && (k % 2 == 0), (k < 8) && (k % 2 == 1), k < 8, 1'b0,
             (k > 0) && (k % 2 == 1), (k > 0) && (k % 2 == 0)};
      eir = ((k > 0) && (k % 2 == 1)) ? init_word(12'h000) : 32'd0;
      edr = ((k > 0) && (k % 2 == 0)) ? init_word(12'h004) : 32'd0;
      @(negedge clk);
      chk($sformatf("b2b%0d", k), {26'd0, flags_now(), bus.if_rdata, bus.d_rdata},
          {26'd0, ef, eir, edr});
      @(posedge clk); #1;
    end

    // Random contention against the model, addresses 0x020..0x02F.
    for (int a = 0; a < 16; a++) rmem[a] = init_word(12'h020 + 12'(a));
    denied  = 0;
    last_rd = 0;
    last_dat = 0;
    begin
      logic        ir, dr, dwe, if_hold, d_hold, e_ig, e_dg;
      logic [11:0] ia, da;
      logic [31:0] wd;
      logic [3:0]  be;
      logic [47:0] e_ram;
      if_hold = 0; d_hold = 0;
      ir = 0; dr = 0; dwe = 0; ia = 0; da = 0; wd = 0; be = 0;
      for (int c = 0; c < 300; c++) begin
        if (!if_hold) begin
          ir = ($urandom_range(0, 3) != 0);
          ia = 12'h020 + 12'($urandom_range(0, 15));
        end
        if (!d_hold) begin
          dr  = ($urandom_range(0, 4) != 0);
          dwe = $urandom_range(0, 1) == 1;
          da  = 12'h020 + 12'($urandom_range(0, 15));
          wd  = $urandom;
          be  = 4'($urandom_range(0, 15));
        end
        drive(1, ir, ia, dr, dwe, da, wd, be);
        e_dg = dr && !(ir && denied >= SM);
        e_ig = ir && !e_dg;
        if (e_dg) e_ram = {da, wd, dwe ? be : 4'h0};
        else if (e_ig) e_ram = {ia, 32'd0, 4'h0};
        else e_ram = 48'd0;
        @(negedge clk);
        chk($sformatf("rnd%0d gnt", c), {92'd0, bus.if_gnt, bus.d_gnt, bus.ram_en, bus.ram_we},
            {92'd0, e_ig, e_dg, e_ig | e_dg, e_dg & dwe});
        chk($sformatf("rnd%0d ram", c), {48'd0, bus.ram_addr, bus.ram_wdata, bus.ram_be},
            {48'd0, e_ram});
        chk($sformatf("rnd%0d resp", c),
            {30'd0, bus.if_rvalid, bus.d_rvalid, bus.if_rdata, bus.d_rdata},
            {30'd0, last_rd == 1, last_rd == 2,
             (last_rd == 1) ? last_dat : 32'd0, (last_rd == 2) ? last_dat : 32'd0});
        last_rd = 0;
        if (e_ig) begin
          last_rd = 1; last_dat = rmem[ia[3:0]];
        end else if (e_dg && !dwe) begin
          last_rd = 2; last_dat = rmem[da[3:0]];
        end else if (e_dg) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) rmem[da[3:0]][8*b +: 8] = wd[8*b +: 8];
        end
        denied  = (ir && !e_ig) ? ((denied + 1 > SM) ? SM : denied + 1) : 0;
        if_hold = ir && !e_ig;
        d_hold  = dr && !e_dg;
        @(posedge clk); #1;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
